// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: FSM state encoding and counter sizing helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count bit positions 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fs.sv
// Combinational 1-bit full subtractor: diff = x - y - bin, with borrow out.
module fs (
    output logic diff,
    output logic bout,
    input  logic x,
    input  logic y,
    input  logic bin
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first: d = a - b - b_in over WIDTH RUN cycles.
module serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-2:0] res_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic             diff_s;
    logic             bout_s;
    logic [WIDTH-1:0] res_next_s;

    fs u_fs (
        .diff (diff_s),
        .bout (bout_s),
        .x    (a_sr_r[0]),
        .y    (b_sr_r[0]),
        .bin  (borrow_r)
    );

    // The last difference bit goes straight into d, so the result register needs only WIDTH-1 bits.
    assign res_next_s = {diff_s, res_r};

    // Handshake FSM, operand shifters, bit counter, borrow flop and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            res_r    <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d        <= '0;
            b_out    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r   <= a;
                        b_sr_r   <= b;
                        borrow_r <= b_in;
                        cnt_r    <= '0;
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_r    <= res_next_s[WIDTH-1:1];
                    borrow_r <= bout_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_r   <= '0;
                        d       <= res_next_s;
                        b_out   <= bout_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial unsigned subtractor: d = a - b - b_in, one bit per clock, LSB first.
- Inverse-direction companion to the combinational full-adder datapath. Gives the arithmetic library a low-area subtract path.
- Built around one shared full-subtractor cell plus shift registers, a borrow flip-flop and a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and difference width in bits; legal range 2..64.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- b_in  input  1  borrow in; captured on the accepted start.
- busy  output  1  high while an operation is in progress (RUN or DONE).
- done  output  1  one-cycle pulse when d and b_out are valid.
- d  output  WIDTH  difference, (a - b - b_in) mod 2^WIDTH.
- b_out  output  1  borrow out; 1 iff a < b + b_in (unsigned).

Behaviour:
- Reset: if rst=1 at a clock edge, all of the following apply at that edge:
  - state = IDLE
  - busy = 0, done = 0, d = 0, b_out = 0
  - internal shift registers, bit counter and borrow flip-flop cleared
  - rst has priority over start and over every state transition, including mid-RUN.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t: load a_sr=a, b_sr=b, borrow_ff=b_in, cnt=0; go to RUN. busy=1 from t+1.
- IDLE, start=0: stay in IDLE. d and b_out hold the last result.
- RUN, per cycle:
  - The full-subtractor cell takes x=a_sr[0], y=b_sr[0], bin=borrow_ff.
  - diff is shifted into the MSB of the result register, which shifts right.
  - a_sr and b_sr shift right; borrow_ff <= bout; cnt <= cnt+1.
  - When cnt reaches WIDTH-1, go to DONE on that edge. RUN lasts exactly WIDTH cycles.
- DONE: lasts one cycle.
  - d = result register, b_out = borrow_ff, done = 1, busy = 1.
  - Next edge returns to IDLE with busy=0, done=0.
- Latency: start accepted at edge t, done high during cycle t+WIDTH+1.
  - Next start can be accepted at edge t+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored. a, b and b_in may change freely after acceptance without effect.
- d and b_out change only on the DONE entry edge and on reset; stable in IDLE and RUN.
- Counter width is clog2(WIDTH) bits. No wrap beyond WIDTH-1 occurs.
- Full-subtractor equations:
  - diff = x ^ y ^ bin
  - bout = (~x & y) | (~(x ^ y) & bin)

Decomposition:
- Shared package (arith_pkg):
  - state enum {IDLE, RUN, DONE}
  - helper function returning counter width as clog2(WIDTH)
- Sub-module fs: combinational 1-bit full subtractor with ports diff, bout, x, y, bin. Reusable by a later ripple subtractor.
- serial_sub contains the FSM, shift registers, counter and borrow flip-flop, and instantiates one fs.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, b_in=0, start one cycle -> done pulses exactly 9 cycles after the start edge; d=0x1E, b_out=0; busy high for 9 cycles.
- a=0x00, b=0x01, b_in=0 -> d=0xFF, b_out=1. Then a=0x80, b=0x7F, b_in=1 -> d=0x00, b_out=0.
- a=0xFF, b=0xFF, b_in=1 -> d=0xFF, b_out=1. Hold start=1 continuously -> ops accepted every 10 cycles, done never high two consecutive cycles.
- Start an op, pulse start with different operands and toggle a/b during RUN -> second request ignored; result matches first operands only.
- Start a=0x5A, b=0x3C, assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, d=0x00, b_out=0. A new start a=0x10, b=0x01 then yields d=0x0F, b_out=0.
- Randomised 1000 ops at WIDTH=8 and WIDTH=13 vs reference model (a - b - b_in) -> all d and b_out match; latency always WIDTH+1.
